// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Groups the raster generator's frame-buffer read port and its VGA pin bus.
//   PIX_TICK     generator -> frame buffer : 1-CLK pixel strobe / read enable
//   VGA_ADDR     generator -> frame buffer : {y>>SCALE_SHIFT, x>>SCALE_SHIFT}
//   VGA_DATA     frame buffer -> generator : 1-bit pixel for VGA_ADDR
//   VGA_HS/VS    generator -> connector    : syncs (polarity set in generator)
//   VGA_DE       generator -> connector    : active-video flag
//   VGA_COLOUR   generator -> connector    : pixel colour, 0 when blanked
//   FRAME_START  generator -> system       : 1-CLK pulse as raster leaves (0,0)
// master = generator side, slave = frame buffer / sink side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int AX_W  = 8,
    parameter int AY_W  = 7,
    parameter int COL_W = 8
);
    logic                   PIX_TICK;
    logic [AY_W+AX_W-1:0]   VGA_ADDR;
    logic                   VGA_DATA;
    logic                   VGA_HS;
    logic                   VGA_VS;
    logic                   VGA_DE;
    logic [COL_W-1:0]       VGA_COLOUR;
    logic                   FRAME_START;

    modport master (
        output PIX_TICK, VGA_ADDR, VGA_HS, VGA_VS, VGA_DE, VGA_COLOUR, FRAME_START,
        input  VGA_DATA
    );

    modport slave (
        input  PIX_TICK, VGA_ADDR, VGA_HS, VGA_VS, VGA_DE, VGA_COLOUR, FRAME_START,
        output VGA_DATA
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster generator. Divides CLK into a pixel tick, runs the
// H/V raster counters, issues scaled frame-buffer read addresses and turns
// the returned 1-bit pixel into fg/bg colour. HS, VS, DE and colour all pass
// through the same 2-tick pipeline so they reach the pins aligned.
// Ports:
//   CLK             system clock
//   RESET           asynchronous, active-high reset
//   ENABLE          0 freezes divider, counters and pipeline
//   CONFIG_COLOURS  {bg, fg}; sampled only at the start of each frame
//   bus             vga_timing_gen_if master (frame-buffer read + VGA pins)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_DISP      = 640,
    parameter int H_FP        = 16,
    parameter int H_PW        = 96,
    parameter int H_BP        = 48,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 10,
    parameter int V_PW        = 2,
    parameter int V_BP        = 29,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int SCALE_SHIFT = 2,
    parameter int AX_W        = 8,
    parameter int AY_W        = 7,
    parameter int COL_W       = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic [2*COL_W-1:0] CONFIG_COLOURS,
    vga_timing_gen_if.master   bus
);

    localparam int H_TOT = H_DISP + H_FP + H_PW + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_PW + V_BP;
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int AW    = AY_W + AX_W;

    localparam logic [DW-1:0] DIV_LAST_C = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_DISP_C   = HW'(H_DISP);
    localparam logic [HW-1:0] H_SS_C     = HW'(H_DISP + H_FP);
    localparam logic [HW-1:0] H_SE_C     = HW'(H_DISP + H_FP + H_PW);
    localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_DISP_C   = VW'(V_DISP);
    localparam logic [VW-1:0] V_SS_C     = VW'(V_DISP + V_FP);
    localparam logic [VW-1:0] V_SE_C     = VW'(V_DISP + V_FP + V_PW);
    localparam logic          HS_ACT_C   = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ACT_C   = (VS_POL != 0) ? 1'b1 : 1'b0;

    // Frame-buffer address: each field is the scaled coordinate, truncated to its width.
    function automatic logic [AW-1:0] raster_addr(input logic [HW-1:0] h,
                                                  input logic [VW-1:0] v);
        logic [HW-1:0] hx;
        logic [VW-1:0] vy;
        hx = h >> SCALE_SHIFT;
        vy = v >> SCALE_SHIFT;
        return {AY_W'(vy), AX_W'(hx)};
    endfunction

    logic [DW-1:0]      div_r;
    logic [HW-1:0]      h_r;
    logic [VW-1:0]      v_r;
    logic [AW-1:0]      addr_r;
    logic               de1_r;
    logic               hs1_r;
    logic               vs1_r;
    logic               de_r;
    logic               hs_r;
    logic               vs_r;
    logic [COL_W-1:0]   colour_r;
    logic [2*COL_W-1:0] col_r;
    logic               pix_tick_r;
    logic               frame_start_r;

    logic               tick_s;
    logic               origin_s;
    logic [COL_W-1:0]   pix_colour_s;

    // Pixel tick strobe and raster-origin detect.
    always_comb begin
        tick_s   = 1'b0;
        origin_s = 1'b0;
        if (ENABLE && (div_r == DIV_LAST_C)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if ((h_r == {HW{1'b0}}) && (v_r == {VW{1'b0}})) begin
            origin_s = 1'b1;
        end else begin
            origin_s = 1'b0;
        end
    end

    // Clock divider; PIX_TICK/FRAME_START are the registered strobes, so they
    // coincide with the first CLK in which the new VGA_ADDR is visible.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_r         <= {DW{1'b0}};
            pix_tick_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pix_tick_r    <= tick_s;
            frame_start_r <= tick_s & origin_s;
            if (tick_s) begin
                div_r <= {DW{1'b0}};
            end else if (ENABLE) begin
                div_r <= div_r + DW'(1);
            end else begin
                div_r <= div_r;
            end
        end
    end

    // Horizontal / vertical raster counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_r <= {HW{1'b0}};
            v_r <= {VW{1'b0}};
        end else if (tick_s) begin
            if (h_r == H_LAST_C) begin
                h_r <= {HW{1'b0}};
                if (v_r == V_LAST_C) begin
                    v_r <= {VW{1'b0}};
                end else begin
                    v_r <= v_r + VW'(1);
                end
            end else begin
                h_r <= h_r + HW'(1);
            end
        end else begin
            h_r <= h_r;
            v_r <= v_r;
        end
    end

    // Stage 1: address and region flags from the counters. The address keeps
    // running through blanking so the frame buffer needs no special casing.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_r <= {AW{1'b0}};
            de1_r  <= 1'b0;
            hs1_r  <= 1'b0;
            vs1_r  <= 1'b0;
        end else if (tick_s) begin
            addr_r <= raster_addr(h_r, v_r);
            de1_r  <= (h_r < H_DISP_C) && (v_r < V_DISP_C);
            hs1_r  <= (h_r >= H_SS_C) && (h_r < H_SE_C);
            vs1_r  <= (v_r >= V_SS_C) && (v_r < V_SE_C);
        end else begin
            addr_r <= addr_r;
            de1_r  <= de1_r;
            hs1_r  <= hs1_r;
            vs1_r  <= vs1_r;
        end
    end

    // Colour latch: reloaded only at the raster origin so a mid-frame change
    // never tears the picture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col_r <= {(2*COL_W){1'b0}};
        end else if (tick_s && origin_s) begin
            col_r <= CONFIG_COLOURS;
        end else begin
            col_r <= col_r;
        end
    end

    // Pixel colour from the frame-buffer bit returned for the stage-1 address.
    always_comb begin
        pix_colour_s = {COL_W{1'b0}};
        if (de1_r) begin
            if (bus.VGA_DATA) begin
                pix_colour_s = col_r[COL_W-1:0];
            end else begin
                pix_colour_s = col_r[2*COL_W-1:COL_W];
            end
        end else begin
            pix_colour_s = {COL_W{1'b0}};
        end
    end

    // Stage 2: pin registers, all delayed by exactly one further tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            colour_r <= {COL_W{1'b0}};
            de_r     <= 1'b0;
            hs_r     <= ~HS_ACT_C;
            vs_r     <= ~VS_ACT_C;
        end else if (tick_s) begin
            colour_r <= pix_colour_s;
            de_r     <= de1_r;
            hs_r     <= hs1_r ? HS_ACT_C : ~HS_ACT_C;
            vs_r     <= vs1_r ? VS_ACT_C : ~VS_ACT_C;
        end else begin
            colour_r <= colour_r;
            de_r     <= de_r;
            hs_r     <= hs_r;
            vs_r     <= vs_r;
        end
    end

    assign bus.PIX_TICK    = pix_tick_r;
    assign bus.FRAME_START = frame_start_r;
    assign bus.VGA_ADDR    = addr_r;
    assign bus.VGA_DE      = de_r;
    assign bus.VGA_HS      = hs_r;
    assign bus.VGA_VS      = vs_r;
    assign bus.VGA_COLOUR  = colour_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench on a reduced raster: CLK_DIV=4, H 24/2/4/2 (32 ticks per
// line = 128 CLKs), V 16/1/2/2 (21 lines per frame = 2688 CLKs).
// cyc counts CLK rising edges since reset release. Raster position k (k-th
// tick after reset) is issued on VGA_ADDR from edge 4(k+1) and reaches the
// DE/HS/VS/colour pins from edge 4(k+2).
// The frame buffer model returns bit 0 of VGA_ADDR (the scaled x lsb), so
// x=0..3 shows bg and x=4..7 shows fg.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] CONFIG_COLOURS;
    int          cyc;
    int          errors;
    int          checks;

    vga_timing_gen_if #(.AX_W(8), .AY_W(7), .COL_W(8)) vif ();

    vga_timing_gen #(
        .CLK_DIV(4), .H_DISP(24), .H_FP(2), .H_PW(4), .H_BP(2),
        .V_DISP(16), .V_FP(1), .V_PW(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .SCALE_SHIFT(2),
        .AX_W(8), .AY_W(7), .COL_W(8)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .CONFIG_COLOURS(CONFIG_COLOURS),
        .bus(vif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge counter since reset release.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Frame-buffer read model: registered read enabled by PIX_TICK.
    always @(posedge CLK or posedge RESET) begin
        if (RESET)             vif.VGA_DATA <= 1'b0;
        else if (vif.PIX_TICK) vif.VGA_DATA <= vif.VGA_ADDR[0];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({vif.VGA_HS, vif.VGA_VS} !== 2'b11) begin
            errors++; $display("FAIL reset_syncs: got %b expected 11", {vif.VGA_HS, vif.VGA_VS});
        end
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h000) begin
            errors++; $display("FAIL reset_de_colour: got %h expected 000", {vif.VGA_DE, vif.VGA_COLOUR});
        end
        checks++;
        if (vif.VGA_ADDR !== 15'h0000) begin
            errors++; $display("FAIL reset_addr: got %h expected 0000", vif.VGA_ADDR);
        end
        checks++;
        if ({vif.PIX_TICK, vif.FRAME_START} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00", {vif.PIX_TICK, vif.FRAME_START});
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (vif.PIX_TICK !== (n == 4)) begin
                errors++; $display("FAIL first_tick edge %0d: got %b expected %b", n, vif.PIX_TICK, (n == 4));
            end
        end
        checks++;
        if (vif.FRAME_START !== 1'b1) begin
            errors++; $display("FAIL first_frame_start: got %b expected 1", vif.FRAME_START);
        end
    endtask

    task automatic test_h_timing;
        int   de_rise1, de_rise2, de_fall, hs_fall, hs_rise;
        logic de_prev, hs_prev;
        de_rise1 = -1; de_rise2 = -1; de_fall = -1; hs_fall = -1; hs_rise = -1;
        do_reset;
        de_prev = vif.VGA_DE;
        hs_prev = vif.VGA_HS;
        while (cyc < 300) begin
            @(posedge CLK);
            #1;
            if (!de_prev && vif.VGA_DE) begin
                if (de_rise1 < 0)      de_rise1 = cyc;
                else if (de_rise2 < 0) de_rise2 = cyc;
            end
            if (de_prev && !vif.VGA_DE && de_fall < 0) de_fall = cyc;
            if (hs_prev && !vif.VGA_HS && hs_fall < 0) hs_fall = cyc;
            if (!hs_prev && vif.VGA_HS && hs_fall >= 0 && hs_rise < 0) hs_rise = cyc;
            de_prev = vif.VGA_DE;
            hs_prev = vif.VGA_HS;
        end
        checks++;
        if (de_rise1 !== 8) begin
            errors++; $display("FAIL h_de_latency: got %0d expected 8", de_rise1);
        end
        checks++;
        if (de_fall - de_rise1 !== 96) begin
            errors++; $display("FAIL h_de_width: got %0d expected 96", de_fall - de_rise1);
        end
        checks++;
        if (hs_fall - de_rise1 !== 104) begin
            errors++; $display("FAIL h_hs_start: got %0d expected 104", hs_fall - de_rise1);
        end
        checks++;
        if (hs_rise - hs_fall !== 16) begin
            errors++; $display("FAIL h_hs_width: got %0d expected 16", hs_rise - hs_fall);
        end
        checks++;
        if (de_rise2 - de_rise1 !== 128) begin
            errors++; $display("FAIL h_line_len: got %0d expected 128", de_rise2 - de_rise1);
        end
    endtask

    task automatic test_v_timing;
        int   vs_fall, vs_rise, fs1, fs2, fs_cnt;
        logic vs_prev;
        vs_fall = -1; vs_rise = -1; fs1 = -1; fs2 = -1; fs_cnt = 0;
        do_reset;
        vs_prev = vif.VGA_VS;
        while (cyc < 2800) begin
            @(posedge CLK);
            #1;
            if (vs_prev && !vif.VGA_VS && vs_fall < 0) vs_fall = cyc;
            if (!vs_prev && vif.VGA_VS && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
            if (vif.FRAME_START) begin
                fs_cnt++;
                if (fs1 < 0)      fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            vs_prev = vif.VGA_VS;
        end
        checks++;
        if (vs_fall !== 2184) begin
            errors++; $display("FAIL v_vs_start: got %0d expected 2184", vs_fall);
        end
        checks++;
        if (vs_rise - vs_fall !== 256) begin
            errors++; $display("FAIL v_vs_width: got %0d expected 256", vs_rise - vs_fall);
        end
        checks++;
        if (fs_cnt !== 2) begin
            errors++; $display("FAIL v_frame_start_count: got %0d expected 2", fs_cnt);
        end
        checks++;
        if ((fs1 !== 4) || (fs2 !== 2692)) begin
            errors++; $display("FAIL v_frame_period: got %0d,%0d expected 4,2692", fs1, fs2);
        end
    endtask

    task automatic test_address;
        do_reset;
        wait_to(764);   // (30,5): horizontal blanking
        checks++;
        if (vif.VGA_ADDR !== 15'h0107) begin
            errors++; $display("FAIL addr_hblank: got %h expected 0107", vif.VGA_ADDR);
        end
        wait_to(1176);  // (5,9)
        checks++;
        if (vif.VGA_ADDR !== 15'h0201) begin
            errors++; $display("FAIL addr_5_9: got %h expected 0201", vif.VGA_ADDR);
        end
        wait_to(2016);  // (23,15): last active pixel
        checks++;
        if (vif.VGA_ADDR !== 15'h0305) begin
            errors++; $display("FAIL addr_last: got %h expected 0305", vif.VGA_ADDR);
        end
        wait_to(2320);  // (3,18): vertical blanking
        checks++;
        if (vif.VGA_ADDR !== 15'h0400) begin
            errors++; $display("FAIL addr_vblank: got %h expected 0400", vif.VGA_ADDR);
        end
    endtask

    task automatic test_colour;
        CONFIG_COLOURS = 16'hE01C;
        do_reset;
        wait_to(8);     // (0,0) -> bg
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h1E0) begin
            errors++; $display("FAIL colour_bg: got %h expected 1e0", {vif.VGA_DE, vif.VGA_COLOUR});
        end
        wait_to(28);    // (5,0) -> fg
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h11C) begin
            errors++; $display("FAIL colour_fg: got %h expected 11c", {vif.VGA_DE, vif.VGA_COLOUR});
        end
        wait_to(108);   // (25,0) -> blanked
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h000) begin
            errors++; $display("FAIL colour_blank: got %h expected 000", {vif.VGA_DE, vif.VGA_COLOUR});
        end
        wait_to(152);   // (4,1) -> fg
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h11C) begin
            errors++; $display("FAIL colour_line1: got %h expected 11c", {vif.VGA_DE, vif.VGA_COLOUR});
        end
    endtask

    task automatic test_midframe_config;
        CONFIG_COLOURS = 16'hE01C;
        do_reset;
        wait_to(1300);  // on line 10
        CONFIG_COLOURS = 16'h03FF;
        wait_to(1564);  // (5,12) same frame -> old fg
        checks++;
        if (vif.VGA_COLOUR !== 8'h1C) begin
            errors++; $display("FAIL midframe_hold: got %h expected 1c", vif.VGA_COLOUR);
        end
        wait_to(2692);
        checks++;
        if (vif.FRAME_START !== 1'b1) begin
            errors++; $display("FAIL midframe_frame_start: got %b expected 1", vif.FRAME_START);
        end
        wait_to(2696);  // next frame (0,0) -> new bg
        checks++;
        if (vif.VGA_COLOUR !== 8'h03) begin
            errors++; $display("FAIL midframe_new_bg: got %h expected 03", vif.VGA_COLOUR);
        end
        wait_to(2716);  // next frame (5,0) -> new fg
        checks++;
        if (vif.VGA_COLOUR !== 8'hFF) begin
            errors++; $display("FAIL midframe_new_fg: got %h expected ff", vif.VGA_COLOUR);
        end
        CONFIG_COLOURS = 16'hE01C;
    endtask

    task automatic test_enable;
        int   pulses, de_fall, de_rise, tick1;
        logic de_prev;
        pulses = 0; de_fall = -1; de_rise = -1; tick1 = -1;
        do_reset;
        wait_to(42);    // last tick at edge 40 issued position 9
        checks++;
        if ({vif.VGA_DE, vif.VGA_ADDR} !== 16'h8002) begin
            errors++; $display("FAIL enable_pre: got %h expected 8002", {vif.VGA_DE, vif.VGA_ADDR});
        end
        ENABLE = 1'b0;
        while (cyc < 92) begin
            @(posedge CLK);
            #1;
            if (vif.PIX_TICK) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL enable_no_tick: got %0d expected 0", pulses);
        end
        checks++;
        if ({vif.VGA_DE, vif.VGA_ADDR} !== 16'h8002) begin
            errors++; $display("FAIL enable_hold: got %h expected 8002", {vif.VGA_DE, vif.VGA_ADDR});
        end
        ENABLE = 1'b1;
        de_prev = vif.VGA_DE;
        while (cyc < 300) begin
            @(posedge CLK);
            #1;
            if (vif.PIX_TICK && tick1 < 0) tick1 = cyc;
            if (de_prev && !vif.VGA_DE && de_fall < 0) de_fall = cyc;
            if (!de_prev && vif.VGA_DE && de_rise < 0) de_rise = cyc;
            de_prev = vif.VGA_DE;
        end
        checks++;
        if (tick1 !== 94) begin
            errors++; $display("FAIL enable_resume_tick: got %0d expected 94", tick1);
        end
        checks++;
        if ((de_fall !== 154) || (de_rise !== 186)) begin
            errors++; $display("FAIL enable_stretch: got fall %0d rise %0d expected 154 186", de_fall, de_rise);
        end
    endtask

    task automatic test_reset_midframe;
        CONFIG_COLOURS = 16'hE01C;
        do_reset;
        wait_to(1580);  // position (10,12) just issued
        checks++;
        if (vif.VGA_ADDR !== 15'h0302) begin
            errors++; $display("FAIL midreset_pre: got %h expected 0302", vif.VGA_ADDR);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({vif.VGA_ADDR, vif.VGA_DE, vif.VGA_HS, vif.VGA_VS, vif.VGA_COLOUR, vif.PIX_TICK}
            !== {15'h0000, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL midreset_async: addr %h de %b hs %b vs %b col %h tick %b expected 0000 0 1 1 00 0",
                               vif.VGA_ADDR, vif.VGA_DE, vif.VGA_HS, vif.VGA_VS, vif.VGA_COLOUR, vif.PIX_TICK);
        end
        @(negedge CLK);
        RESET = 1'b0;
        wait_to(4);
        checks++;
        if ({vif.FRAME_START, vif.VGA_ADDR} !== 16'h8000) begin
            errors++; $display("FAIL midreset_restart: got %h expected 8000", {vif.FRAME_START, vif.VGA_ADDR});
        end
        wait_to(8);
        checks++;
        if ({vif.VGA_DE, vif.VGA_COLOUR} !== 9'h1E0) begin
            errors++; $display("FAIL midreset_first_pixel: got %h expected 1e0", {vif.VGA_DE, vif.VGA_COLOUR});
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        RESET          = 1'b1;
        ENABLE         = 1'b1;
        CONFIG_COLOURS = 16'hE01C;
        test_reset;
        test_h_timing;
        test_v_timing;
        test_address;
        test_colour;
        test_midframe_config;
        test_enable;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
